// File: rtl/scroll_frame_gen.sv
// rtl/scroll_frame_gen.sv - 7-column scrolling window over a 5-row message buffer
module scroll_frame_gen #(
    parameter int MSG_LEN = 32
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ch0,
    input  logic        ch1,
    input  logic        shift_tick,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [4:0]  wr_data,
    output logic [34:0] frame,
    output logic [4:0]  pos,
    output logic        frame_upd
);

    typedef enum logic [1:0] {
        HOLD  = 2'b00,
        LEFT  = 2'b01,
        RIGHT = 2'b10,
        BLANK = 2'b11
    } mode_t;

    localparam logic [5:0] LEN6 = 6'(MSG_LEN);
    localparam logic [4:0] LAST = 5'(MSG_LEN - 1);

    logic        ch0_m, ch0_s, ch1_m, ch1_s;
    mode_t       mode;
    logic [4:0]  msg_buf [MSG_LEN];
    logic [4:0]  pos_next;
    logic [34:0] frame_next;
    logic [5:0]  col_idx;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ch0_m <= 1'b0;
            ch0_s <= 1'b0;
            ch1_m <= 1'b0;
            ch1_s <= 1'b0;
        end else begin
            ch0_m <= ch0;
            ch0_s <= ch0_m;
            ch1_m <= ch1;
            ch1_s <= ch1_m;
        end
    end

    assign mode = mode_t'({ch1_s, ch0_s});

    always_comb begin
        pos_next = pos;
        unique case (mode)
            HOLD:  pos_next = pos;
            LEFT:  if (shift_tick) pos_next = (pos == LAST) ? 5'd0 : pos + 5'd1;
            RIGHT: if (shift_tick) pos_next = (pos == 5'd0) ? LAST : pos - 5'd1;
            BLANK: pos_next = 5'd0;
        endcase
    end

    // pos_next < MSG_LEN and k <= 6 < MSG_LEN, so one conditional subtract wraps the index
    always_comb begin
        frame_next = '0;
        col_idx    = '0;
        for (int k = 0; k < 7; k++) begin
            col_idx = {1'b0, pos_next} + 6'(k);
            if (col_idx >= LEN6) begin
                col_idx = col_idx - LEN6;
            end
            frame_next[k*5 +: 5] = msg_buf[col_idx[4:0]];
        end
        if (mode == BLANK) begin
            frame_next = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_buf[i] <= 5'd0;
            end
        end else if (wr_en && ({1'b0, wr_addr} < LEN6)) begin
            msg_buf[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pos       <= 5'd0;
            frame     <= '0;
            frame_upd <= 1'b0;
        end else begin
            pos       <= pos_next;
            frame     <= frame_next;
            frame_upd <= (frame_next != frame);
        end
    end

endmodule

// File: tb/tb_scroll_frame_gen.sv
// tb/tb_scroll_frame_gen.sv - directed and randomized checks of scroll_frame_gen against a reference model
module tb_scroll_frame_gen;

    localparam int L = 32;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        ch0 = 1'b0;
    logic        ch1 = 1'b0;
    logic        shift_tick = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [4:0]  wr_data = '0;
    logic [34:0] frame;
    logic [4:0]  pos;
    logic        frame_upd;

    int tests = 0;
    int failed = 0;

    int          m_pos;
    int          m_buf [L];
    logic [34:0] m_frame;
    logic        m_upd;
    int          m_hist1, m_hist2;

    scroll_frame_gen #(.MSG_LEN(L)) dut (
        .CLK(CLK), .RST_N(RST_N), .ch0(ch0), .ch1(ch1),
        .shift_tick(shift_tick), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame(frame), .pos(pos), .frame_upd(frame_upd)
    );

    always #5 CLK = ~CLK;

    function automatic logic [34:0] window(input int p);
        logic [34:0] f;
        f = '0;
        for (int k = 0; k < 7; k++) f[k*5 +: 5] = 5'(m_buf[(p + k) % L]);
        return f;
    endfunction

    task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Mode seen at an edge is the switch setting that was present two edges earlier.
    task automatic model_edge();
        int mode;
        int np;
        logic [34:0] nf;
        if (!RST_N) begin
            m_pos = 0; m_frame = '0; m_upd = 1'b0; m_hist1 = 0; m_hist2 = 0;
            for (int i = 0; i < L; i++) m_buf[i] = 0;
            return;
        end
        mode = m_hist2;
        np = m_pos;
        if (mode == 1 && shift_tick) np = (m_pos + 1) % L;
        if (mode == 2 && shift_tick) np = (m_pos + L - 1) % L;
        if (mode == 3) np = 0;
        nf = (mode == 3) ? 35'd0 : window(np);
        if (wr_en && int'(wr_addr) < L) m_buf[wr_addr] = int'(wr_data);
        m_upd = (nf != m_frame);
        m_frame = nf;
        m_pos = np;
        m_hist2 = m_hist1;
        m_hist1 = {ch1, ch0};
    endtask

    task automatic step(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        chk({tag, ".pos"}, 35'(pos), 35'(m_pos));
        chk({tag, ".frame"}, frame, m_frame);
        chk({tag, ".upd"}, 35'(frame_upd), 35'(m_upd));
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic set_mode(input logic [1:0] m);
        {ch1, ch0} = m;
        shift_tick = 1'b0;
        run(3, "mode_sync");
    endtask

    logic [34:0] exp_c;
    logic [4:0]  old3;

    initial begin
        m_pos = 0; m_frame = '0; m_upd = 1'b0; m_hist1 = 0; m_hist2 = 0;
        for (int i = 0; i < L; i++) m_buf[i] = 0;

        // reset
        run(2, "reset");
        chk("reset_pos", 35'(pos), 35'd0);
        chk("reset_frame", frame, 35'd0);
        chk("reset_upd", 35'(frame_upd), 35'd0);
        RST_N = 1'b1;

        // fill columns 0..6 under HOLD
        for (int i = 0; i < 7; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i);
            case (i)
                0: wr_data = 5'h01; 1: wr_data = 5'h02; 2: wr_data = 5'h04;
                3: wr_data = 5'h08; 4: wr_data = 5'h10; 5: wr_data = 5'h1F;
                default: wr_data = 5'h11;
            endcase
            step("write");
        end
        wr_en = 1'b0;
        step("write_done");
        exp_c = {5'h11, 5'h1F, 5'h10, 5'h08, 5'h04, 5'h02, 5'h01};
        chk("hold_frame", frame, exp_c);
        chk("hold_upd", 35'(frame_upd), 35'd1);
        wr_en = 1'b1; wr_addr = 5'd30; wr_data = 5'h0A; step("w30");
        wr_addr = 5'd31; wr_data = 5'h15; step("w31");
        wr_en = 1'b0;

        // RIGHT: wrap 0 -> 31, then three held ticks -> 28
        set_mode(2'b10);
        shift_tick = 1'b1; step("right_wrap");
        chk("right_wrap_pos", 35'(pos), 35'd31);
        run(3, "right_hold");
        chk("right_three_pos", 35'(pos), 35'd28);

        // LEFT: 28 -> 30 window wrap, then 31 -> 0
        set_mode(2'b01);
        shift_tick = 1'b1; run(2, "left");
        chk("left_pos30", 35'(pos), 35'd30);
        chk("left_c1c3", frame[14:0], {5'h01, 5'h15, 5'h0A});
        run(1, "left");
        shift_tick = 1'b1; step("left_wrap");
        chk("left_wrap_pos", 35'(pos), 35'd0);
        chk("left_wrap_c1", 35'(frame[4:0]), 35'h01);

        // BLANK from pos 12, then back to HOLD
        run(12, "to12");
        chk("pos12", 35'(pos), 35'd12);
        shift_tick = 1'b0;
        {ch1, ch0} = 2'b11;
        run(3, "blank");
        chk("blank_pos", 35'(pos), 35'd0);
        chk("blank_frame", frame, 35'd0);
        set_mode(2'b00);
        chk("unblank_frame", frame, exp_c);

        // write coincident with tick
        set_mode(2'b01);
        shift_tick = 1'b1; run(2, "to2");
        chk("pos2", 35'(pos), 35'd2);
        old3 = frame[9:5];
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 5'h13;
        step("wr_tick");
        wr_en = 1'b0; shift_tick = 1'b0;
        chk("wr_tick_c1_old", 35'(frame[4:0]), 35'(old3));
        step("wr_tick_after");
        chk("wr_tick_c1_new", 35'(frame[4:0]), 35'h13);

        // reset mid-scroll wins over write and tick
        shift_tick = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 5'h1E;
        run(3, "busy");
        RST_N = 1'b0; step("mid_reset");
        chk("mid_reset_pos", 35'(pos), 35'd0);
        chk("mid_reset_frame", frame, 35'd0);
        RST_N = 1'b1; wr_en = 1'b0;
        run(2, "post_reset");
        chk("post_reset_pos", 35'(pos), 35'd0);
        shift_tick = 1'b0; run(1, "post_reset");
        chk("cleared_frame", frame, 35'd0);

        // randomized
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(15) == 0) {ch1, ch0} = 2'($urandom_range(3));
            shift_tick = 1'($urandom_range(1));
            wr_en = ($urandom_range(2) == 0);
            wr_addr = 5'($urandom);
            wr_data = 5'($urandom);
            RST_N = ($urandom_range(199) != 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/scroll_frame_gen.md
SCROLL_FRAME_GEN -- requirements
Module: scroll_frame_gen

Interface
REQ-001 Parameter MSG_LEN, default 32, number of 5-bit message columns held in the buffer (legal range 8..32).
REQ-002 CLK  input  1  single system clock; every register in the block is clocked on its rising edge.
REQ-003 RST_N  input  1  reset, synchronous and active-low.
REQ-004 ch0  input  1  mode switch bit 0, asynchronous to CLK.
REQ-005 ch1  input  1  mode switch bit 1, asynchronous to CLK.
REQ-006 shift_tick  input  1  one-cycle scroll enable from the frequency divider.
REQ-007 wr_en  input  1  message buffer write strobe.
REQ-008 wr_addr  input  5  column index to write; writes with wr_addr >= MSG_LEN are ignored.
REQ-009 wr_data  input  5  column pattern; bit 0 = row L1 ... bit 4 = row L5.
REQ-010 frame  output  35  displayed window, consumed by the matrix scanner; bit (c-1)*5+(r-1) = column Cc, row Lr, 1 = LED on.
REQ-011 pos  output  5  buffer index shown in column C1.
REQ-012 frame_upd  output  1  one-cycle pulse whenever frame changes value.

Function
REQ-013 ch1/ch0 SHALL each pass through a 2-flop synchronizer; the effective mode is {ch1_s,ch0_s}, applied 2 cycles after an input change.
REQ-014 Mode 00 HOLD: pos frozen; shift_tick ignored.
REQ-015 Mode 01 LEFT: on shift_tick, pos <= pos+1; pos = MSG_LEN-1 wraps to 0.
REQ-016 Mode 10 RIGHT: on shift_tick, pos <= pos-1; pos = 0 wraps to MSG_LEN-1.
REQ-017 Mode 11 BLANK: pos <= 0 on every cycle regardless of shift_tick, and frame is forced to all zeros.
REQ-018 Outside BLANK, the frame column Ck (k = 1..7) SHALL equal buf[(pos_next+k-1) mod MSG_LEN], where pos_next is the pos value being registered in the same cycle.
REQ-019 frame SHALL be registered every cycle, giving a latency of 1 cycle from tick, write or mode change to visible frame; pos and frame update on the same edge.
REQ-020 A buffer write SHALL take effect at the clock edge; the frame registered on that edge uses the pre-write contents, and the new data appears one cycle later.
REQ-021 Writes are accepted in every mode, including BLANK.
REQ-022 If wr_en and shift_tick coincide, both SHALL act: the scroll occurs first and the written data is visible 1 cycle later (per REQ-020).
REQ-023 frame_upd SHALL be 1 in the cycle after any edge on which the frame register value changed, and 0 otherwise.
REQ-024 A shift_tick held high for N cycles SHALL scroll N positions; there is no edge detection.
REQ-025 Window wrap: with pos near MSG_LEN-1, columns SHALL index modulo MSG_LEN, and no out-of-range buffer read SHALL occur.

Reset
REQ-026 While RST_N = 0 at an edge, the following SHALL hold:
  - pos = 0, frame = 0, frame_upd = 0.
  - All buffer columns = 5'b00000.
  - Synchronizer flops = 0, so the mode is HOLD.
REQ-027 Reset asserted mid-scroll or coincident with wr_en/shift_tick SHALL win: the write is discarded and no scroll occurs.
REQ-028 After RST_N rises, the mode becomes valid 2 cycles later; shift_tick arriving before then is ignored under HOLD.

Verification
REQ-029 Reset, then write buf[0..6] = 01,02,04,08,10,1F,11 (hex) in HOLD -> frame = {11,1F,10,08,04,02,01} (C7..C1), with frame_upd pulsing after the writes.
REQ-030 Mode 01, MSG_LEN = 32, pos = 31, one shift_tick -> pos = 0 on the next edge; C1 = buf[0].
   Mode 01, pos = 30 -> C1 = buf[30], C2 = buf[31], C3 = buf[0].
REQ-031 Mode 10, pos = 0, shift_tick -> pos = 31.
   Then 3 consecutive tick cycles -> pos = 28.
REQ-032 Set ch1 = ch0 = 1 with pos = 12 -> 2 cycles later pos = 0 and frame = 0.
   Then return to 00 -> frame = buf[0..6] one cycle after the mode takes effect.
REQ-033 wr_en to column 3 coincident with shift_tick in mode 01 from pos = 2 -> pos = 3 and C1 shows the old buf[3], then the new wr_data one cycle later.
REQ-034 RST_N low for 1 cycle during active scrolling and writing -> all outputs 0 next cycle and buffer cleared.
   After release, a tick arriving within 2 cycles leaves pos = 0.
